arbitro_morra: RTL and testbench
================================

ARBITRO_MORRA -- requirements
Module: arbitro_morra

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles a buffered move waits for the opponent's move.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  request a new match; sampled on clk.
REQ-005 P1_VALID / P1_MOVE / P1_READY  in/in/out  1/2/1  player-1 move handshake.
REQ-006 P2_VALID / P2_MOVE / P2_READY  in/in/out  1/2/1  player-2 move handshake.
REQ-007 CORE_PRIMO / CORE_SECONDO / CORE_INIZIA  out/out/out  2/2/1  drive the MorraCinese core inputs.
REQ-008 CORE_MANCHE / CORE_PARTITA  in/in  2/2  core outputs, registered, valid the cycle after the move pair is driven.
REQ-009 RES_VALID / RES_READY  out/in  1/1  result handshake to the consumer.
REQ-010 RES_MANCHE / RES_PARTITA  out/out  2/2  captured round and match result.
REQ-011 TIMEOUT  output  1  one-cycle pulse when a pending round is abandoned.
REQ-012 BUSY  output  1  high in every state except IDLE and DONE.

Function
REQ-013 Move encoding SHALL be 00 invalid, 01 sasso, 10 carta, 11 forbice; MANCHE 00 none, 01 P1, 10 P2, 11 draw; PARTITA 00 ongoing, 01 P1, 10 P2, 11 draw.
REQ-014 FSM states SHALL be IDLE, COLLECT, ISSUE, CAPTURE, REPORT, DONE.
REQ-015 START=1 in any state SHALL drive CORE_INIZIA=1 with CORE_PRIMO=CORE_SECONDO=00 in that cycle, clear both move buffers and the timeout counter, and enter COLLECT next cycle; START overrides every other event.
REQ-016 Outside ISSUE, CORE_PRIMO and CORE_SECONDO SHALL be 00, and CORE_INIZIA SHALL be 0 unless REQ-015 applies.
REQ-017 In COLLECT, Pn_READY SHALL be 1 iff player n's buffer is empty; READY SHALL be 0 in all other states.
REQ-018 A transfer occurs on a clk edge with Pn_VALID&Pn_READY; a transferred move 00 SHALL be discarded and the buffer stays empty.
REQ-019 When both buffers are full (including both filled in the same cycle), the FSM SHALL enter ISSUE on the next edge.
REQ-020 ISSUE SHALL last exactly one cycle, driving CORE_PRIMO=buffer1 and CORE_SECONDO=buffer2, then enter CAPTURE.
REQ-021 CAPTURE SHALL register CORE_MANCHE and CORE_PARTITA into RES_MANCHE and RES_PARTITA, clear both buffers, and enter REPORT.
REQ-022 In REPORT, RES_VALID SHALL be 1 with stable RES_* until RES_READY=1 at an edge; the FSM then goes to DONE if RES_PARTITA!=00, else to COLLECT.
REQ-023 RES_MANCHE and RES_PARTITA SHALL hold their last values until the next CAPTURE or reset.
REQ-024 The timeout counter SHALL run in COLLECT while exactly one buffer is full, counting from 1 on the cycle after the first fill.
REQ-025 When the count reaches TIMEOUT_CYCLES and the other buffer is still empty, the block SHALL clear both buffers, pulse TIMEOUT for one cycle, and remain in COLLECT.
REQ-026 If the second move arrives on the same edge as the timeout, the arrival SHALL win: no TIMEOUT, and the FSM enters ISSUE.
REQ-027 DONE SHALL ignore VALID inputs (READY=0) until START.
REQ-028 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and the counter SHALL saturate, never wrap.

Reset
REQ-029 RST=1 SHALL asynchronously force IDLE, empty buffers, counter 0, and all outputs 0, including mid-round.
REQ-030 After RST is released, the FSM SHALL stay in IDLE, with READY=0, until START.

Structure
REQ-031 A shared package morra_pkg SHALL hold the move, MANCHE and PARTITA encodings and the FSM state enum.
REQ-032 The block SHALL contain one sub-module, morra_move_slot (2-bit buffer, full flag, READY generation), instantiated once per player.
REQ-033 arbitro_morra SHALL NOT instantiate the MorraCinese core; the integration level connects them.

Verification
REQ-034 Scenario 1: RST, then START, then P1 sends 10 and P2 sends 01 in the same cycle -> ISSUE drives 10/01 for one cycle, and RES_MANCHE=01 in REPORT.
REQ-035 Scenario 2: P1 sends 11 at cycle t and P2 stays idle, with TIMEOUT_CYCLES=16 -> TIMEOUT pulses at t+16, P1_READY returns to 1, and no ISSUE occurs.
REQ-036 Scenario 3: P2 sends its move on the exact timeout edge -> no TIMEOUT pulse, and ISSUE follows.
REQ-037 Scenario 4: hold RES_READY=0 for 5 cycles in REPORT -> RES_VALID and RES_* stay stable and both READYs stay 0.
REQ-038 Scenario 5: play the core to PARTITA=01 -> DONE, P1_VALID is ignored, and START returns to COLLECT with CORE_INIZIA=1 for exactly one cycle.
REQ-039 Scenario 6: assert RST during ISSUE -> all outputs are 0 immediately (asynchronously), and the FSM is in IDLE.

Source files
------------

// File: rtl/morra_pkg.sv
// Shared encodings for the morra arbiter: moves, round/match results and FSM states.
package morra_pkg;

  typedef enum logic [1:0] {
    MOVE_NONE    = 2'b00,
    MOVE_SASSO   = 2'b01,
    MOVE_CARTA   = 2'b10,
    MOVE_FORBICE = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    MANCHE_NONE = 2'b00,
    MANCHE_P1   = 2'b01,
    MANCHE_P2   = 2'b10,
    MANCHE_DRAW = 2'b11
  } manche_t;

  typedef enum logic [1:0] {
    PARTITA_ONGOING = 2'b00,
    PARTITA_P1      = 2'b01,
    PARTITA_P2      = 2'b10,
    PARTITA_DRAW    = 2'b11
  } partita_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ISSUE,
    ST_CAPTURE,
    ST_REPORT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/arbitro_morra_if.sv
// Player move handshakes, core drive/return and result handshake of the morra arbiter.
interface arbitro_morra_if;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic       p2_ready;
  logic [1:0] core_primo;
  logic [1:0] core_secondo;
  logic       core_inizia;
  logic [1:0] core_manche;
  logic [1:0] core_partita;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_manche;
  logic [1:0] res_partita;

  modport slave (
    input  p1_valid, p1_move, p2_valid, p2_move, core_manche, core_partita, res_ready,
    output p1_ready, p2_ready, core_primo, core_secondo, core_inizia,
           res_valid, res_manche, res_partita
  );

  modport master (
    output p1_valid, p1_move, p2_valid, p2_move, core_manche, core_partita, res_ready,
    input  p1_ready, p2_ready, core_primo, core_secondo, core_inizia,
           res_valid, res_manche, res_partita
  );
endinterface

// File: rtl/morra_move_slot.sv
// One-move buffer for a player: accepts a non-zero move while enabled and empty.
module morra_move_slot
  import morra_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_clear,
  input  logic       i_valid,
  input  logic [1:0] i_move,
  output logic       o_ready,
  output logic       o_load,
  output logic       o_full,
  output logic [1:0] o_move
);

  logic       r_full;
  logic [1:0] r_move;

  assign o_ready = i_en & ~r_full;
  // An invalid move completes the handshake but is dropped
  assign o_load  = i_valid & o_ready & (i_move != MOVE_NONE);
  assign o_full  = r_full;
  assign o_move  = r_move;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_move <= MOVE_NONE;
    end else if (i_clear) begin
      r_full <= 1'b0;
      r_move <= MOVE_NONE;
    end else if (o_load) begin
      r_full <= 1'b1;
      r_move <= i_move;
    end
  end

endmodule

// File: rtl/arbitro_morra.sv
// Morra round arbiter: collects both moves, drives the core for one cycle, reports the result.
//   state   | meaning
//   IDLE    | after reset, waiting for START
//   COLLECT | gathering moves, timeout counter runs with one move pending
//   ISSUE   | one cycle driving the move pair to the core
//   CAPTURE | core results registered, buffers cleared
//   REPORT  | result offered until RES_READY
//   DONE    | match decided, waiting for START
module arbitro_morra
  import morra_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  output logic            o_timeout,
  output logic            o_busy,
  arbitro_morra_if.slave  bus
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [1:0]    r_res_manche, r_res_partita;

  logic       w_start, w_collect, w_clear, w_timeout;
  logic       w_ready1, w_load1, w_full1, w_full1_nxt;
  logic       w_ready2, w_load2, w_full2, w_full2_nxt;
  logic [1:0] w_move1, w_move2;

  // Gated so that every output is 0 while reset is held
  assign w_start     = i_start & ~rst;
  assign w_collect   = (r_state == ST_COLLECT);
  assign w_full1_nxt = w_full1 | w_load1;
  assign w_full2_nxt = w_full2 | w_load2;
  // A second move landing on the terminal-count edge wins over the timeout
  assign w_timeout   = w_collect & ~w_start & (r_cnt == CNT_MAX) &
                       (w_full1 ^ w_full2) & ~w_load1 & ~w_load2;
  assign w_clear     = w_start | w_timeout | (r_state == ST_CAPTURE);

  morra_move_slot u_slot1 (
    .clk(clk), .rst(rst), .i_en(w_collect), .i_clear(w_clear),
    .i_valid(bus.p1_valid), .i_move(bus.p1_move),
    .o_ready(w_ready1), .o_load(w_load1), .o_full(w_full1), .o_move(w_move1)
  );

  morra_move_slot u_slot2 (
    .clk(clk), .rst(rst), .i_en(w_collect), .i_clear(w_clear),
    .i_valid(bus.p2_valid), .i_move(bus.p2_move),
    .o_ready(w_ready2), .o_load(w_load2), .o_full(w_full2), .o_move(w_move2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_res_manche  <= MANCHE_NONE;
      r_res_partita <= PARTITA_ONGOING;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == ST_CAPTURE && !w_start) begin
        r_res_manche  <= bus.core_manche;
        r_res_partita <= bus.core_partita;
      end
    end
  end

  always_comb begin
    w_next           = r_state;
    w_cnt_next       = '0;
    bus.core_primo   = MOVE_NONE;
    bus.core_secondo = MOVE_NONE;
    bus.core_inizia  = w_start;
    bus.res_valid    = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_COLLECT: begin
        if (w_full1_nxt && w_full2_nxt)
          w_next = ST_ISSUE;
        else if (!w_timeout && (w_full1_nxt ^ w_full2_nxt))
          w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      end
      ST_ISSUE: begin
        bus.core_primo   = w_move1;
        bus.core_secondo = w_move2;
        w_next           = ST_CAPTURE;
      end
      ST_CAPTURE: w_next = ST_REPORT;
      ST_REPORT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready)
          w_next = (r_res_partita != PARTITA_ONGOING) ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: ;
      default: w_next = ST_IDLE;
    endcase
    if (w_start) begin
      w_next           = ST_COLLECT;
      w_cnt_next       = '0;
      bus.core_primo   = MOVE_NONE;
      bus.core_secondo = MOVE_NONE;
    end
  end

  assign o_busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_timeout       = w_timeout;
  assign bus.p1_ready    = w_ready1;
  assign bus.p2_ready    = w_ready2;
  assign bus.res_manche  = r_res_manche;
  assign bus.res_partita = r_res_partita;

endmodule

// File: tb/tb_arbitro_morra.sv
// Directed plus randomized rounds of the morra arbiter against a rule-level reference model.
module tb_arbitro_morra;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic timeout, busy;
  int total = 0;
  int bad = 0;
  int w1 = 0;
  int w2 = 0;

  arbitro_morra_if bus();

  arbitro_morra #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .i_start(start),
    .o_timeout(timeout), .o_busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  // Environment stand-in for the MorraCinese core: registered outputs, first to 3 wins
  int cs1, cs2;
  logic [1:0] cm, cp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cs1 <= 0; cs2 <= 0; cm <= 2'b00; cp <= 2'b00;
    end else if (bus.core_inizia) begin
      cs1 <= 0; cs2 <= 0; cm <= 2'b00; cp <= 2'b00;
    end else if (bus.core_primo != 2'b00 && bus.core_secondo != 2'b00) begin
      case ({bus.core_primo, bus.core_secondo})
        4'b1001, 4'b1110, 4'b0111: begin
          cs1 <= cs1 + 1; cm <= 2'b01; cp <= (cs1 >= 2) ? 2'b01 : 2'b00;
        end
        4'b0110, 4'b1011, 4'b1101: begin
          cs2 <= cs2 + 1; cm <= 2'b10; cp <= (cs2 >= 2) ? 2'b10 : 2'b00;
        end
        default: cm <= 2'b11;
      endcase
    end
  end
  assign bus.core_manche  = cm;
  assign bus.core_partita = cp;

  function automatic logic [1:0] exp_manche(input int m1, input int m2);
    int d;
    d = (m1 - m2 + 3) % 3;
    return (d == 0) ? 2'b11 : ((d == 1) ? 2'b01 : 2'b10);
  endfunction

  function automatic logic [1:0] exp_partita();
    return (w1 >= 3) ? 2'b01 : ((w2 >= 3) ? 2'b10 : 2'b00);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    #1;
    chk("start_inizia", bus.core_inizia, 1);
    chk("start_primo", bus.core_primo, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("post_start_inizia", bus.core_inizia, 0);
    chk("post_start_busy", busy, 1);
    chk("post_start_rdy1", bus.p1_ready, 1);
    chk("post_start_rdy2", bus.p2_ready, 1);
    w1 = 0;
    w2 = 0;
  endtask

  // Returns just after the edge that completes the second transfer
  task automatic collect(input logic [1:0] m1, input logic [1:0] m2,
                         input int d1, input int d2, input bit z1, input bit z2);
    int c;
    bit s1, s2, h1, h2;
    c = 0; s1 = 0; s2 = 0;
    while (!(s1 && s2)) begin
      if (c > 60) begin
        chk("collect_budget", 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "collect did not complete");
      end
      @(negedge clk);
      bus.p1_valid = !s1 && (c >= d1);
      bus.p1_move  = (z1 && c == d1) ? 2'b00 : m1;
      bus.p2_valid = !s2 && (c >= d2);
      bus.p2_move  = (z2 && c == d2) ? 2'b00 : m2;
      #1;
      chk("col_rdy1", bus.p1_ready, !s1);
      chk("col_rdy2", bus.p2_ready, !s2);
      chk("col_timeout", timeout, 0);
      h1 = bus.p1_valid && bus.p1_ready && (bus.p1_move != 2'b00);
      h2 = bus.p2_valid && bus.p2_ready && (bus.p2_move != 2'b00);
      @(posedge clk);
      if (h1) s1 = 1;
      if (h2) s2 = 1;
      c++;
    end
  endtask

  task automatic finish_round(input logic [1:0] m1, input logic [1:0] m2, input int hold);
    logic [1:0] em, ep;
    @(negedge clk);
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    #1;
    chk("issue_primo", bus.core_primo, m1);
    chk("issue_secondo", bus.core_secondo, m2);
    chk("issue_busy", busy, 1);
    chk("issue_rdy1", bus.p1_ready, 0);
    chk("issue_resv", bus.res_valid, 0);
    @(negedge clk);
    #1;
    chk("capt_primo", bus.core_primo, 0);
    chk("capt_secondo", bus.core_secondo, 0);
    em = exp_manche(int'(m1), int'(m2));
    if (em == 2'b01) w1++;
    else if (em == 2'b10) w2++;
    ep = exp_partita();
    @(negedge clk);
    #1;
    chk("rep_valid", bus.res_valid, 1);
    chk("rep_manche", bus.res_manche, em);
    chk("rep_partita", bus.res_partita, ep);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_manche", bus.res_manche, em);
      chk("hold_partita", bus.res_partita, ep);
      chk("hold_rdy1", bus.p1_ready, 0);
      chk("hold_rdy2", bus.p2_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("after_rep_resv", bus.res_valid, 0);
    chk("after_rep_busy", busy, (ep != 2'b00) ? 1'b0 : 1'b1);
    chk("after_rep_rdy1", bus.p1_ready, (ep != 2'b00) ? 1'b0 : 1'b1);
  endtask

  task automatic timeout_round(input bit late);
    @(negedge clk);
    bus.p1_valid = 1'b1;
    bus.p1_move  = 2'b11;
    #1;
    chk("to_first_rdy", bus.p1_ready, 1);
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bus.p1_valid = 1'b0;
      if (late && k == 16) begin
        bus.p2_valid = 1'b1;
        bus.p2_move  = 2'b01;
      end
      #1;
      chk((k < 16 || late) ? "to_quiet" : "to_pulse", timeout, (k == 16 && !late) ? 1 : 0);
      chk("to_rdy1", bus.p1_ready, 0);
      chk("to_rdy2", bus.p2_ready, 1);
      chk("to_no_issue", bus.core_primo, 0);
    end
    if (late) begin
      @(posedge clk);
      finish_round(2'b11, 2'b01, 0);
    end else begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        #1;
        chk("to_after_pulse", timeout, 0);
        chk("to_after_rdy1", bus.p1_ready, 1);
        chk("to_after_rdy2", bus.p2_ready, 1);
        chk("to_after_primo", bus.core_primo, 0);
        chk("to_after_busy", busy, 1);
      end
    end
  endtask

  task automatic done_ignore();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.p1_valid = 1'b1;
      bus.p1_move  = 2'b10;
      #1;
      chk("done_rdy1", bus.p1_ready, 0);
      chk("done_busy", busy, 0);
      chk("done_inizia", bus.core_inizia, 0);
    end
    @(negedge clk);
    bus.p1_valid = 1'b0;
    #1;
    chk("done_no_issue", bus.core_primo, 0);
  endtask

  initial begin
    logic [1:0] m1, m2;
    bus.p1_valid = 1'b0; bus.p1_move = 2'b00;
    bus.p2_valid = 1'b0; bus.p2_move = 2'b00;
    bus.res_ready = 1'b0;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rdy1", bus.p1_ready, 0);
    chk("rst_resv", bus.res_valid, 0);
    chk("rst_manche", bus.res_manche, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.p1_valid = 1'b1;
    bus.p1_move  = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_rdy1", bus.p1_ready, 0);
      chk("idle_rdy2", bus.p2_ready, 0);
    end
    bus.p1_valid = 1'b0;

    do_start();
    collect(2'b10, 2'b01, 0, 0, 0, 0);
    finish_round(2'b10, 2'b01, 5);

    timeout_round(1'b0);
    timeout_round(1'b1);

    for (int r = 0; r < 20; r++) begin
      m1 = 2'($urandom_range(1, 3));
      m2 = 2'($urandom_range(1, 3));
      collect(m1, m2, $urandom_range(0, 8), $urandom_range(0, 8),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      finish_round(m1, m2, $urandom_range(0, 3));
      if (exp_partita() != 2'b00) begin
        done_ignore();
        do_start();
      end
    end

    do_start();
    for (int r = 0; r < 3; r++) begin
      m2 = 2'($urandom_range(1, 3));
      m1 = 2'((int'(m2) % 3) + 1);
      collect(m1, m2, $urandom_range(0, 4), $urandom_range(0, 4), 0, 0);
      finish_round(m1, m2, $urandom_range(0, 2));
    end
    chk("match_p1", bus.res_partita, 2'b01);
    done_ignore();
    do_start();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("inizia_once", bus.core_inizia, 0);
    end

    collect(2'b10, 2'b11, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("pre_rst_issue", bus.core_primo, 2'b10);
    rst = 1'b1;
    #1;
    chk("arst_primo", bus.core_primo, 0);
    chk("arst_secondo", bus.core_secondo, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy1", bus.p1_ready, 0);
    chk("arst_resv", bus.res_valid, 0);
    chk("arst_manche", bus.res_manche, 0);
    chk("arst_partita", bus.res_partita, 0);
    chk("arst_inizia", bus.core_inizia, 0);
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rdy1", bus.p1_ready, 0);
    end
    do_start();
    collect(2'b01, 2'b11, 1, 0, 0, 0);
    finish_round(2'b01, 2'b11, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
